mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction / data) arbiter in front of a single RAM port.
// Data requests win by default. After STARVE_LIMIT consecutive data completions while an
// instruction fetch waits, the instruction side gets the next grant.
// Address, data and read-data paths are combinational. Only the grant state, the
// starvation counter and the sticky error flag are registered.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [ADDR_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic              dwait,
  output logic [ADDR_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] scnt;

  logic dreq;
  logic ram_done;
  logic i_done;
  logic d_done;
  logic starve_hit;

  assign dreq       = dREN | dWEN;
  // ACCESS and ERROR both end the transaction; FREE and BUSY keep it open.
  assign ram_done   = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);
  assign i_done     = (state == IGRANT) && ram_done;
  assign d_done     = (state == DGRANT) && ram_done;
  assign starve_hit = iREN && (scnt == LIMIT);

  // Grant FSM, starvation counter and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      scnt  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && !starve_hit) state <= DGRANT;
          else if (iREN)           state <= IGRANT;
          else                     state <= IDLE;
        end
        IGRANT: begin
          // Completion or an abandoned request both hand the port back.
          if (ram_done || !iREN) state <= IDLE;
        end
        DGRANT: begin
          if (ram_done || !dreq) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Clearing has priority over counting.
      if (!iREN || i_done) begin
        scnt <= '0;
      end else if (d_done && (scnt != LIMIT)) begin
        scnt <= scnt + CW'(1);
      end

      if ((i_done || d_done) && (ramstate == RAM_ERROR)) begin
        err <= 1'b1;
      end
    end
  end

  // RAM port mux: strobes follow the live request so a dropped request releases them at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
      end
    endcase
  end

  // Stall each requester until the cycle its own grant completes.
  always_comb begin
    iwait = iREN & ~i_done;
    dwait = dreq & ~d_done;
  end

  assign iload = ramload;
  assign dload = ramload;

endmodule
